// File: rtl/pipeline_sequencer.sv
// Pipeline run-control: stage enables, bubbles, PC enable,
// per-stage valid tracking, debug modes and counters.
module pipeline_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int HAZ_STAGE  = 1,
  parameter int CNT_WIDTH  = 32,
  parameter int STEP_WIDTH = 8,
  parameter int RESET_RUN  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  input  logic [STEP_WIDTH-1:0] i_step_count,
  input  logic                  i_ext_stall,
  input  logic                  i_hazard,
  input  logic                  i_flush,
  input  logic                  i_fetch_valid,
  output logic                  o_pc_en,
  output logic [NUM_STAGES-1:0] o_stage_en,
  output logic [NUM_STAGES-1:0] o_bubble,
  output logic [NUM_STAGES-1:0] o_stage_valid,
  output logic [1:0]            o_state,
  output logic                  o_step_done,
  output logic                  o_cmd_err,
  output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
  output logic [CNT_WIDTH-1:0]  o_retired_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_DRAIN = 2'b11
  } state_e;

  localparam state_e RST_STATE =
    (RESET_RUN != 0) ? S_RUN : S_HALT;
  localparam int LAST = NUM_STAGES - 1;

  state_e                  state_q, state_d;
  logic [NUM_STAGES-1:0]   valid_q, valid_d;
  logic [CNT_WIDTH-1:0]    cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]    ret_q, ret_d;
  logic [STEP_WIDTH-1:0]   rem_q, rem_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    adv;
  logic                    drain;
  logic                    halted;
  logic [NUM_STAGES-1:0]   stage_en;
  logic [NUM_STAGES-1:0]   bubble;
  logic                    pc_en;
  logic [NUM_STAGES-1:0]   shift_in;
  logic                    is_run;
  logic                    is_step;
  logic                    is_halt;
  logic                    is_drain;

  assign halted = (state_q == S_HALT);
  assign drain  = (state_q == S_DRAIN);
  assign adv    = !halted && !i_ext_stall;

  assign is_run   = (i_cmd == 2'b00);
  assign is_step  = (i_cmd == 2'b01);
  assign is_halt  = (i_cmd == 2'b10);
  assign is_drain = (i_cmd == 2'b11);

  // Hazard freezes the front registers and PC; flush is
  // dropped under hazard so the branch re-evaluates later.
  always_comb begin
    stage_en = '0;
    bubble   = '0;
    pc_en    = 1'b0;
    if (adv) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_en[k] = !(i_hazard && (k < HAZ_STAGE));
      end
      bubble[HAZ_STAGE] = i_hazard;
      bubble[0] = (i_flush && !i_hazard) || drain;
      pc_en = !i_hazard && !drain;
    end
  end

  assign shift_in = {valid_q[NUM_STAGES-2:0], i_fetch_valid};

  // Valid bits shift with the pipe, cleared by bubbles.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_en[k]) begin
        valid_d[k] = bubble[k] ? 1'b0 : shift_in[k];
      end
    end
  end

  // Counters advance only on cycles the pipe moves.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (adv) begin
      cyc_d = cyc_q + 1'b1;
      if (valid_q[LAST]) begin
        ret_d = ret_q + 1'b1;
      end
    end
  end

  // Mode FSM: STEP/DRAIN completion, then command handling
  // so that a HALT command cancels a same-cycle done.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (adv && state_q == S_STEP) begin
      if (rem_q <= STEP_WIDTH'(1)) begin
        rem_d   = '0;
        state_d = S_HALT;
        done_d  = 1'b1;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
    if (adv && drain && valid_d == '0) begin
      state_d = S_HALT;
      done_d  = 1'b1;
    end
    if (i_cmd_valid) begin
      unique case (1'b1)
        is_halt: begin
          state_d = S_HALT;
          done_d  = 1'b0;
        end
        is_run: begin
          if (halted) state_d = S_RUN;
          else        err_d   = 1'b1;
        end
        is_step: begin
          if (halted) begin
            state_d = S_STEP;
            rem_d   = (i_step_count == '0) ?
                      STEP_WIDTH'(1) : i_step_count;
          end else begin
            err_d = 1'b1;
          end
        end
        is_drain: begin
          if (halted) state_d = S_DRAIN;
          else        err_d   = 1'b1;
        end
        default: err_d = 1'b0;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RST_STATE;
      valid_q <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_pc_en       = pc_en;
  assign o_stage_en    = stage_en;
  assign o_bubble      = bubble;
  assign o_stage_valid = valid_q;
  assign o_state       = state_q;
  assign o_step_done   = done_q;
  assign o_cmd_err     = err_q;
  assign o_cycle_cnt   = cyc_q;
  assign o_retired_cnt = ret_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed
// scenarios then random traffic against a mode model.
module tb_pipeline_sequencer;

  localparam int NS = 5;
  localparam int HZ = 1;
  localparam int CW = 32;
  localparam int SW = 8;

  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic [SW-1:0] step_count;
  logic          ext_stall;
  logic          hazard;
  logic          flush;
  logic          fetch_valid;
  logic          pc_en;
  logic [NS-1:0] stage_en;
  logic [NS-1:0] bubble;
  logic [NS-1:0] stage_valid;
  logic [1:0]    state;
  logic          step_done;
  logic          cmd_err;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] retired_cnt;

  pipeline_sequencer #(
    .NUM_STAGES(NS), .HAZ_STAGE(HZ), .CNT_WIDTH(CW),
    .STEP_WIDTH(SW), .RESET_RUN(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_step_count(step_count), .i_ext_stall(ext_stall),
    .i_hazard(hazard), .i_flush(flush),
    .i_fetch_valid(fetch_valid),
    .o_pc_en(pc_en), .o_stage_en(stage_en),
    .o_bubble(bubble), .o_stage_valid(stage_valid),
    .o_state(state), .o_step_done(step_done),
    .o_cmd_err(cmd_err), .o_cycle_cnt(cycle_cnt),
    .o_retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int      st;
    bit      v[NS];
    bit [CW-1:0] cyc;
    bit [CW-1:0] ret;
    bit      done;
    bit      err;
    bit      pc;
    bit      en[NS];
    bit      bub[NS];
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model of the sequencer.
  int          m_st;
  bit          m_v[NS];
  bit [CW-1:0] m_cyc;
  bit [CW-1:0] m_ret;
  int          m_rem;
  bit          m_done;
  bit          m_err;

  function automatic void m_reset();
    m_st = M_HALT;
    foreach (m_v[k]) m_v[k] = 1'b0;
    m_cyc = '0;
    m_ret = '0;
    m_rem = 0;
    m_done = 1'b0;
    m_err = 1'b0;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, req);
    end
  endtask

  function automatic logic [NS-1:0] pack(input bit a[NS]);
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = a[k];
    return r;
  endfunction

  // One cycle: drive inputs, record what the DUT must show
  // this cycle, then advance the model across the edge.
  task automatic cyc(input bit r, input bit cv,
                     input bit [1:0] c, input int cnt,
                     input bit stl, input bit hz,
                     input bit fl, input bit fv);
    exp_t e;
    bit adv;
    bit nv[NS];
    bit empty;
    @(posedge clk);
    #1;
    rst_n = r;
    cmd_valid = cv;
    cmd = c;
    step_count = SW'(cnt);
    ext_stall = stl;
    hazard = hz;
    flush = fl;
    fetch_valid = fv;

    adv = (m_st != M_HALT) && !stl;
    e.st = m_st;
    e.v = m_v;
    e.cyc = m_cyc;
    e.ret = m_ret;
    e.done = m_done;
    e.err = m_err;
    e.pc = adv && !hz && (m_st != M_DRAIN);
    for (int k = 0; k < NS; k++) begin
      e.en[k] = adv && !(hz && k < HZ);
      e.bub[k] = 1'b0;
    end
    if (adv && hz) e.bub[HZ] = 1'b1;
    if (adv && ((fl && !hz) || m_st == M_DRAIN))
      e.bub[0] = 1'b1;
    exp_q.push_back(e);

    if (!r) begin
      m_reset();
      return;
    end
    nv = m_v;
    for (int k = 0; k < NS; k++) begin
      if (e.en[k]) begin
        if (e.bub[k]) nv[k] = 1'b0;
        else if (k == 0) nv[k] = fv;
        else nv[k] = m_v[k-1];
      end
    end
    m_done = 1'b0;
    m_err = 1'b0;
    if (adv) begin
      m_cyc = m_cyc + 1;
      if (m_v[NS-1]) m_ret = m_ret + 1;
    end
    if (adv && m_st == M_STEP) begin
      m_rem = m_rem - 1;
      if (m_rem <= 0) begin
        m_st = M_HALT;
        m_done = 1'b1;
      end
    end
    empty = 1'b1;
    foreach (nv[k]) if (nv[k]) empty = 1'b0;
    if (adv && m_st == M_DRAIN && empty) begin
      m_st = M_HALT;
      m_done = 1'b1;
    end
    if (cv) begin
      if (c == 2'b10) begin
        m_st = M_HALT;
        m_done = 1'b0;
      end else if (e.st != M_HALT) begin
        m_err = 1'b1;
      end else if (c == 2'b00) begin
        m_st = M_RUN;
      end else if (c == 2'b01) begin
        m_st = M_STEP;
        m_rem = (cnt == 0) ? 1 : cnt;
      end else begin
        m_st = M_DRAIN;
      end
    end
    m_v = nv;
  endtask

  // Monitor: compares every DUT output mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", 64'(state), 64'(e.st));
      chk("stage_valid", 64'(stage_valid), 64'(pack(e.v)));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
      chk("retired_cnt", 64'(retired_cnt), 64'(e.ret));
      chk("step_done", 64'(step_done), 64'(e.done));
      chk("cmd_err", 64'(cmd_err), 64'(e.err));
      chk("pc_en", 64'(pc_en), 64'(e.pc));
      chk("stage_en", 64'(stage_en), 64'(pack(e.en)));
      chk("bubble", 64'(bubble), 64'(pack(e.bub)));
    end
  end

  localparam bit [1:0] C_RUN = 2'b00;
  localparam bit [1:0] C_STP = 2'b01;
  localparam bit [1:0] C_HLT = 2'b10;
  localparam bit [1:0] C_DRN = 2'b11;

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 2'b00;
    step_count = '0;
    ext_stall = 1'b0;
    hazard = 1'b0;
    flush = 1'b0;
    fetch_valid = 1'b0;
    m_reset();

    // reset, then RUN and fill
    cyc(0, 0, C_RUN, 0, 0, 0, 0, 0);
    cyc(0, 0, C_RUN, 0, 0, 0, 0, 0);
    cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    cyc(1, 1, C_RUN, 0, 0, 0, 0, 1);
    repeat (6) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // hazard, flush, flush under hazard
    cyc(1, 0, C_RUN, 0, 0, 1, 0, 1);
    cyc(1, 0, C_RUN, 0, 0, 0, 1, 1);
    cyc(1, 0, C_RUN, 0, 0, 1, 1, 1);
    cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // RUN while running, then HALT
    cyc(1, 1, C_RUN, 0, 0, 0, 0, 1);
    cyc(1, 1, C_HLT, 0, 0, 0, 0, 1);
    cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // STEP 3 with a stall in its 2nd cycle
    cyc(1, 1, C_STP, 3, 0, 0, 0, 1);
    cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    cyc(1, 0, C_RUN, 0, 1, 0, 0, 1);
    repeat (4) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // STEP 0 counts as one
    cyc(1, 1, C_STP, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // refill, halt, drain
    cyc(1, 1, C_RUN, 0, 0, 0, 0, 1);
    repeat (6) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    cyc(1, 1, C_HLT, 0, 0, 0, 0, 1);
    cyc(1, 1, C_DRN, 0, 0, 0, 0, 1);
    repeat (7) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // drain on empty pipe
    cyc(1, 1, C_DRN, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // HALT aborting STEP
    cyc(1, 1, C_STP, 6, 0, 0, 0, 1);
    cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    cyc(1, 1, C_HLT, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    // reset mid-DRAIN
    cyc(1, 1, C_DRN, 0, 0, 0, 0, 1);
    cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);
    cyc(0, 0, C_RUN, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, C_RUN, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 399) != 0,
          $urandom_range(0, 9) == 0,
          2'($urandom_range(0, 3)),
          int'($urandom_range(0, 7)),
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 3) != 0);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
